// File: rtl/rt_pixel_sequencer.sv
// Raster-scan pixel dispatcher between frame control and one ray-trace core.
// Define RTPS_CONTINUOUS_EN to restart the scan automatically after every frame.
module rt_pixel_sequencer #(
   parameter int unsigned H_RES = 640,
   parameter int unsigned V_RES = 480,
   parameter int unsigned X_W   = 10,
   parameter int unsigned Y_W   = 9,
   parameter int unsigned PIX_W = 4
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             FRAME_START,
   output logic             ENABLE,
   output logic [X_W-1:0]   X,
   output logic [Y_W-1:0]   Y,
   input  logic             OUTPUT_READY,
   input  logic [PIX_W-1:0] OUTPUT_PIXEL,
   output logic             PIX_VALID,
   input  logic             PIX_READY,
   output logic [X_W-1:0]   PIX_X,
   output logic [Y_W-1:0]   PIX_Y,
   output logic [PIX_W-1:0] PIX_DATA,
   output logic             FRAME_DONE,
   output logic             BUSY
);

   typedef enum logic [2:0] {StIdle, StIssue, StGuard, StWait, StOut} state_e;

   localparam logic [X_W-1:0] XMax = X_W'(H_RES - 1);
   localparam logic [Y_W-1:0] YMax = Y_W'(V_RES - 1);

   state_e             state_q;
   logic               enable_q;
   logic [X_W-1:0]     x_q;
   logic [Y_W-1:0]     y_q;
   logic               pix_valid_q;
   logic [X_W-1:0]     pix_x_q;
   logic [Y_W-1:0]     pix_y_q;
   logic [PIX_W-1:0]   pix_data_q;
   logic               frame_done_q;
   logic               busy_q;

   logic last_x, last_y;
   assign last_x = (x_q == XMax);
   assign last_y = (y_q == YMax);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= StIdle;
         enable_q     <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         pix_valid_q  <= 1'b0;
         pix_x_q      <= '0;
         pix_y_q      <= '0;
         pix_data_q   <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         enable_q     <= 1'b0;
         frame_done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (FRAME_START) begin
                  state_q  <= StIssue;
                  enable_q <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end
            StIssue: state_q <= StGuard;
            // The core's ready level still reflects the previous pixel here.
            StGuard: state_q <= StWait;
            StWait: begin
               if (OUTPUT_READY) begin
                  pix_data_q  <= OUTPUT_PIXEL;
                  pix_x_q     <= x_q;
                  pix_y_q     <= y_q;
                  pix_valid_q <= 1'b1;
                  state_q     <= StOut;
               end
            end
            StOut: begin
               if (PIX_READY) begin
                  pix_valid_q <= 1'b0;
                  if (!last_x) begin
                     x_q <= x_q + 1'b1;
                  end else begin
                     x_q <= '0;
                     y_q <= last_y ? '0 : y_q + 1'b1;
                  end
                  // Registered, so the pulse lands while PIX_X/PIX_Y still show the last pixel.
                  if (last_x && last_y) begin
                     frame_done_q <= 1'b1;
`ifdef RTPS_CONTINUOUS_EN
                     state_q      <= StIssue;
                     enable_q     <= 1'b1;
`else
                     state_q      <= StIdle;
                     busy_q       <= 1'b0;
`endif
                  end else begin
                     state_q  <= StIssue;
                     enable_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ENABLE     = enable_q;
   assign X          = x_q;
   assign Y          = y_q;
   assign PIX_VALID  = pix_valid_q;
   assign PIX_X      = pix_x_q;
   assign PIX_Y      = pix_y_q;
   assign PIX_DATA   = pix_data_q;
   assign FRAME_DONE = frame_done_q;
   assign BUSY       = busy_q;

endmodule
